// File: rtl/fluid_pkg.sv
// fluid_pkg: shared types and constants for the fluid dispense station.
//   - fluid type encoding, response message codes
//   - per-litre prices, reset stock level, low-stock threshold
//   - loyalty discount tier function (incremented visit count -> percent)
package fluid_pkg;

    typedef enum logic [1:0] {
        FLUID_WATER   = 2'b00,
        FLUID_JUICE   = 2'b01,
        FLUID_CHEM    = 2'b10,
        FLUID_INVALID = 2'b11
    } fluid_e;

    localparam logic [7:0]  MSG_OK             = 8'd0;
    localparam logic [7:0]  MSG_RESTOCK_NEEDED = 8'd1;
    localparam logic [7:0]  MSG_INVALID_FLUID  = 8'd2;

    localparam logic [15:0] WATER_PRICE = 16'd10;
    localparam logic [15:0] JUICE_PRICE = 16'd30;
    localparam logic [15:0] CHEM_PRICE  = 16'd50;
    localparam logic [15:0] INIT_STOCK  = 16'd50;
    localparam logic [15:0] LOW_THRESH  = 16'd10;

    localparam int NUM_USERS  = 16;
    localparam int NUM_FLUIDS = 3;

    // Loyalty tier from the visit count that includes the current request.
    function automatic logic [7:0] discount_tier(input logic [7:0] visits);
        logic [7:0] pct;
        if (visits <= 8'd1) begin
            pct = 8'd0;
        end else if (visits == 8'd2) begin
            pct = 8'd5;
        end else if (visits <= 8'd4) begin
            pct = 8'd10;
        end else begin
            pct = 8'd20;
        end
        return pct;
    endfunction

endpackage

// File: rtl/visit_counter_bank.sv
// visit_counter_bank: 16 saturating 8-bit visit counters.
//   clk, reset (async active-low)
//   inc_en      : increment the selected user's counter on this edge
//   user_id     : selected user
//   count_next  : selected counter + 1 (saturating), combinational, so the
//                 pricing logic sees the count including this request
module visit_counter_bank
    import fluid_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       inc_en,
    input  logic [3:0] user_id,
    output logic [7:0] count_next
);

    logic [7:0] cnt_q [NUM_USERS];

    // Saturating increment of the selected counter.
    always_comb begin
        if (cnt_q[user_id] == 8'hFF) begin
            count_next = 8'hFF;
        end else begin
            count_next = cnt_q[user_id] + 8'd1;
        end
    end

    // Counter storage; only the selected user is written.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_USERS; i++) begin
                cnt_q[i] <= 8'd0;
            end
        end else if (inc_en) begin
            cnt_q[user_id] <= count_next;
        end
    end

endmodule

// File: rtl/fluid_dispense_station.sv
// fluid_dispense_station: pay-per-litre dispenser with loyalty discount.
//   Request in : req_valid, user_id, fluid_type, volume_l
//   Restock in : restock_valid, restock_type, restock_qty (no response)
//   Response   : resp_valid (1-cycle pulse), visits, original_price,
//                discount_percent, final_price, remaining_qty, message;
//                all registered, held between responses.
//   Optional   : LOW_STOCK_ALARM_EN adds low_stock[2:0] (stock < LOW_THRESH).
//   reset is asynchronous active-low.
module fluid_dispense_station
    import fluid_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [3:0]  user_id,
    input  logic [1:0]  fluid_type,
    input  logic [7:0]  volume_l,
    input  logic        restock_valid,
    input  logic [1:0]  restock_type,
    input  logic [7:0]  restock_qty,
`ifdef LOW_STOCK_ALARM_EN
    output logic [2:0]  low_stock,
`endif
    output logic        resp_valid,
    output logic [7:0]  visits,
    output logic [15:0] original_price,
    output logic [7:0]  discount_percent,
    output logic [15:0] final_price,
    output logic [15:0] remaining_qty,
    output logic [7:0]  message
);

    logic [15:0] stock_q [NUM_FLUIDS];
    logic [15:0] stock_d [NUM_FLUIDS];

    logic        resp_valid_q;
    logic [7:0]  visits_q, disc_q, message_q;
    logic [15:0] orig_q, final_q, remain_q;
    logic [7:0]  visits_d, disc_d, message_d;
    logic [15:0] orig_d, final_d, remain_d;

    logic [7:0]  count_next_s;
    logic [15:0] unit_price_s;
    logic [15:0] gross_s;
    logic [7:0]  tier_s;
    logic [23:0] disc_amt_s;
    logic        invalid_s, short_s, dispense_s;

    visit_counter_bank u_visits (
        .clk        (clk),
        .reset      (reset),
        .inc_en     (req_valid),
        .user_id    (user_id),
        .count_next (count_next_s)
    );

    // Unit price lookup.
    always_comb begin
        case (fluid_type)
            FLUID_WATER: unit_price_s = WATER_PRICE;
            FLUID_JUICE: unit_price_s = JUICE_PRICE;
            FLUID_CHEM:  unit_price_s = CHEM_PRICE;
            default:     unit_price_s = 16'd0;
        endcase
    end

    // Pricing, outcome classification and stock commit.
    always_comb begin
        invalid_s  = (fluid_type == FLUID_INVALID);
        // Judged against pre-restock stock, even when a restock lands this cycle.
        short_s    = !invalid_s && ({8'd0, volume_l} > stock_q[fluid_type]);
        dispense_s = req_valid && !invalid_s && !short_s;
        gross_s    = unit_price_s * {8'd0, volume_l};
        tier_s     = discount_tier(count_next_s);
        disc_amt_s = {8'd0, gross_s} * {16'd0, tier_s};

        for (int i = 0; i < NUM_FLUIDS; i++) begin
            logic [16:0] sum_v;
            stock_d[i] = stock_q[i];
            if (dispense_s && (fluid_type == 2'(i))) begin
                stock_d[i] = stock_q[i] - {8'd0, volume_l};
            end else begin
                stock_d[i] = stock_q[i];
            end
            sum_v = {1'b0, stock_d[i]} + {9'd0, restock_qty};
            if (restock_valid && (restock_type == 2'(i))) begin
                stock_d[i] = sum_v[16] ? 16'hFFFF : sum_v[15:0];
            end else begin
                stock_d[i] = stock_d[i];
            end
        end

        visits_d  = count_next_s;
        if (invalid_s) begin
            message_d = MSG_INVALID_FLUID;
            orig_d    = 16'd0;
            disc_d    = 8'd0;
            final_d   = 16'd0;
            remain_d  = 16'd0;
        end else if (short_s) begin
            message_d = MSG_RESTOCK_NEEDED;
            orig_d    = 16'd0;
            disc_d    = 8'd0;
            final_d   = 16'd0;
            remain_d  = stock_d[fluid_type];
        end else begin
            message_d = MSG_OK;
            orig_d    = gross_s;
            disc_d    = tier_s;
            final_d   = gross_s - 16'(disc_amt_s / 24'd100);
            remain_d  = stock_d[fluid_type];
        end
    end

    // Stock and response registers; response fields hold without a request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_FLUIDS; i++) begin
                stock_q[i] <= INIT_STOCK;
            end
            resp_valid_q <= 1'b0;
            visits_q     <= 8'd0;
            orig_q       <= 16'd0;
            disc_q       <= 8'd0;
            final_q      <= 16'd0;
            remain_q     <= 16'd0;
            message_q    <= 8'd0;
        end else begin
            for (int i = 0; i < NUM_FLUIDS; i++) begin
                stock_q[i] <= stock_d[i];
            end
            resp_valid_q <= req_valid;
            if (req_valid) begin
                visits_q  <= visits_d;
                orig_q    <= orig_d;
                disc_q    <= disc_d;
                final_q   <= final_d;
                remain_q  <= remain_d;
                message_q <= message_d;
            end
        end
    end

`ifdef LOW_STOCK_ALARM_EN
    logic [2:0] low_q;

    // Low-stock flags track the committed stock levels.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            low_q <= 3'b000;
        end else begin
            for (int i = 0; i < NUM_FLUIDS; i++) begin
                low_q[i] <= (stock_d[i] < LOW_THRESH);
            end
        end
    end

    assign low_stock = low_q;
`endif

    assign resp_valid       = resp_valid_q;
    assign visits           = visits_q;
    assign original_price   = orig_q;
    assign discount_percent = disc_q;
    assign final_price      = final_q;
    assign remaining_qty    = remain_q;
    assign message          = message_q;

endmodule

// File: tb/tb_fluid_dispense_station.sv
module tb_fluid_dispense_station;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic [3:0]  user_id = 4'd0;
    logic [1:0]  fluid_type = 2'd0;
    logic [7:0]  volume_l = 8'd0;
    logic        restock_valid = 1'b0;
    logic [1:0]  restock_type = 2'd0;
    logic [7:0]  restock_qty = 8'd0;
    logic        resp_valid;
    logic [7:0]  visits;
    logic [15:0] original_price;
    logic [7:0]  discount_percent;
    logic [15:0] final_price;
    logic [15:0] remaining_qty;
    logic [7:0]  message;
`ifdef LOW_STOCK_ALARM_EN
    logic [2:0]  low_stock;
`endif

    fluid_dispense_station dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .user_id          (user_id),
        .fluid_type       (fluid_type),
        .volume_l         (volume_l),
        .restock_valid    (restock_valid),
        .restock_type     (restock_type),
        .restock_qty      (restock_qty),
`ifdef LOW_STOCK_ALARM_EN
        .low_stock        (low_stock),
`endif
        .resp_valid       (resp_valid),
        .visits           (visits),
        .original_price   (original_price),
        .discount_percent (discount_percent),
        .final_price      (final_price),
        .remaining_qty    (remaining_qty),
        .message          (message)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: plain per-user visit counts and per-fluid stock litres.
    int m_visits [16];
    int m_stock  [3];
    int e_valid, e_visits, e_orig, e_disc, e_final, e_remain, e_msg;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_visits[i] = 0;
        for (int i = 0; i < 3; i++) m_stock[i] = 50;
        e_valid = 0; e_visits = 0; e_orig = 0; e_disc = 0;
        e_final = 0; e_remain = 0; e_msg = 0;
    endtask

    function automatic int price_of(input int f);
        if (f == 0) return 10;
        if (f == 1) return 30;
        return 50;
    endfunction

    function automatic int tier_of(input int v);
        if (v == 1) return 0;
        if (v == 2) return 5;
        if (v <= 4) return 10;
        return 20;
    endfunction

    // Apply one cycle of inputs to the reference model.
    task automatic model_step(input int rq, input int u, input int f, input int vol,
                              input int rsv, input int rt, input int rqty);
        int ok;
        ok = 0;
        e_valid = rq;
        if (rq != 0) begin
            if (m_visits[u] < 255) m_visits[u]++;
            e_visits = m_visits[u];
            e_orig = 0; e_disc = 0; e_final = 0;
            if (f == 3) begin
                e_msg = 2;
            end else if (vol > m_stock[f]) begin
                e_msg = 1;
            end else begin
                e_msg  = 0;
                ok     = 1;
                e_orig = price_of(f) * vol;
                e_disc = tier_of(m_visits[u]);
                e_final = e_orig - (e_orig * e_disc) / 100;
                m_stock[f] -= vol;
            end
        end
        if (rsv != 0 && rt != 3) begin
            m_stock[rt] += rqty;
            if (m_stock[rt] > 65535) m_stock[rt] = 65535;
        end
        if (rq != 0) e_remain = (f == 3) ? 0 : m_stock[f];
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, ".resp_valid"}, resp_valid, e_valid);
        check_eq({tag, ".visits"}, visits, e_visits);
        check_eq({tag, ".original_price"}, original_price, e_orig);
        check_eq({tag, ".discount"}, discount_percent, e_disc);
        check_eq({tag, ".final_price"}, final_price, e_final);
        check_eq({tag, ".remaining_qty"}, remaining_qty, e_remain);
        check_eq({tag, ".message"}, message, e_msg);
`ifdef LOW_STOCK_ALARM_EN
        for (int i = 0; i < 3; i++)
            check_eq({tag, ".low_stock"}, low_stock[i], (m_stock[i] < 10) ? 1 : 0);
`endif
    endtask

    task automatic do_cycle(input string tag, input int rq, input int u, input int f,
                            input int vol, input int rsv, input int rt, input int rqty);
        @(negedge clk);
        req_valid     = (rq != 0);
        user_id       = 4'(u);
        fluid_type    = 2'(f);
        volume_l      = 8'(vol);
        restock_valid = (rsv != 0);
        restock_type  = 2'(rt);
        restock_qty   = 8'(rqty);
        model_step(rq, u, f, vol, rsv, rt, rqty);
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        model_reset();
        #12;
        check_outputs("reset");
        reset = 1'b1;

        // Directed sequence.
        do_cycle("u1_w1",  1, 1, 0, 1, 0, 0, 0);
        check_eq("u1_w1.final_const", final_price, 10);
        do_cycle("u1_w2",  1, 1, 0, 2, 0, 0, 0);
        check_eq("u1_w2.final_const", final_price, 19);
        do_cycle("u1_j5",  1, 1, 1, 5, 0, 0, 0);
        check_eq("u1_j5.final_const", final_price, 135);
        do_cycle("u1_w1a", 1, 1, 0, 1, 0, 0, 0);
        do_cycle("u1_w1b", 1, 1, 0, 1, 0, 0, 0);
        check_eq("visit5.final_const", final_price, 8);
        check_eq("visit5.remain_const", remaining_qty, 45);
        do_cycle("u4_c3",  1, 4, 2, 3, 0, 0, 0);
        do_cycle("u6_c70", 1, 6, 2, 70, 0, 0, 0);
        check_eq("u6_c70.msg_const", message, 1);
        do_cycle("inval",  1, 7, 3, 9, 0, 0, 0);
        do_cycle("idle",   0, 0, 0, 0, 0, 0, 0);
        do_cycle("c60_rs", 1, 8, 2, 60, 1, 2, 30);
        check_eq("c60_rs.remain_const", remaining_qty, 77);
        do_cycle("c60",    1, 8, 2, 60, 0, 0, 0);
        check_eq("c60.remain_const", remaining_qty, 17);
        do_cycle("vol0",   1, 9, 1, 0, 0, 0, 0);
        do_cycle("rs_t3",  0, 0, 0, 0, 1, 3, 200);
        do_cycle("j_max",  1, 2, 1, 46, 0, 0, 0);

        // Mid-sequence reset with a request pending on the edge.
        @(negedge clk);
        req_valid = 1'b1; user_id = 4'd3; fluid_type = 2'd0; volume_l = 8'd5;
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_outputs("async_rst");
        @(posedge clk);
        #1;
        check_outputs("rst_drop");
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;
        do_cycle("post_rst", 1, 3, 2, 0, 0, 0, 0);
        do_cycle("post_w",   1, 3, 0, 50, 0, 0, 0);

        // Stock saturation with idle request cycles.
        for (int i = 0; i < 260; i++)
            do_cycle("sat", 0, 0, 0, 0, 1, 1, 255);
        do_cycle("sat_rd", 1, 5, 1, 1, 0, 0, 0);

        // Randomized traffic; few users so visit counts saturate.
        for (int i = 0; i < 1400; i++) begin
            int rq, f, vol, rsv;
            rq  = ($urandom_range(0, 9) < 8) ? 1 : 0;
            f   = $urandom_range(0, 3);
            vol = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 20);
            rsv = ($urandom_range(0, 3) == 0) ? 1 : 0;
            do_cycle("rand", rq, $urandom_range(0, 3), f, vol, rsv,
                     $urandom_range(0, 3), $urandom_range(0, 60));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fluid_dispense_station.md
Name: fluid_dispense_station

Overview:
Pay-per-litre fluid dispenser with a per-user loyalty discount. It keeps a visit counter for each of 16 users and an on-hand stock level for each of 3 fluids. Each accepted request is priced, discounted, checked against stock and committed, with a registered one-cycle response. It sits between the user/kiosk front end and the billing/display logic.

Parameters:
WATER_PRICE, 10, Rs per litre for fluid 2'b00
JUICE_PRICE, 30, Rs per litre for fluid 2'b01
CHEM_PRICE, 50, Rs per litre for fluid 2'b10
INIT_STOCK, 50, litres of each fluid loaded at reset
LOW_THRESH, 10, low-stock alarm threshold in litres (optional feature only)

Ports:
clk  in  1  single clock; rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  request strobe, sampled on the clock edge
user_id  in  4  requesting user, 0..15
fluid_type  in  2  00 water, 01 juice, 10 chemical, 11 invalid
volume_l  in  8  requested litres
restock_valid  in  1  restock strobe
restock_type  in  2  fluid to restock
restock_qty  in  8  litres to add
resp_valid  out  1  one-cycle pulse marking a response
visits  out  8  user's visit count including this request
original_price  out  16  unit_price*volume
discount_percent  out  8  applied discount
final_price  out  16  discounted price
remaining_qty  out  16  stock of the requested fluid after the request
message  out  8  0 OK, 1 RESTOCK_NEEDED, 2 INVALID_FLUID

Behaviour:
- Reset (reset=0, asynchronous): all visit counters 0; all stocks INIT_STOCK; every output 0.
- Request accepted on a clock edge with req_valid=1. All outputs are registered with 1-cycle latency. resp_valid is high for exactly the cycle after acceptance.
- With req_valid=0, state is unchanged, resp_valid=0 and the other outputs hold.
- Visit counting:
  - Every accepted request increments visits[user_id], saturating at 255.
  - The visits output carries the incremented value.
  - Invalid and restock-needed requests are still counted.
- Discount tiers, using the incremented count: 1 → 0%; 2 → 5%; 3–4 → 10%; 5 or more → 20%.
- Pricing:
  - original = unit_price*volume, in 16 bits (maximum 12750, no overflow).
  - final = original − floor(original*disc/100).
  - Use a 24-bit intermediate for the product.
- Outcomes:
  - fluid 11: message=2; prices, discount and remaining_qty are 0; no stock change.
  - volume > stock[fluid]: message=1; prices and discount 0; remaining_qty = current stock, unchanged.
  - Otherwise: message=0; stock −= volume; remaining_qty = new stock.
  - volume=0 is OK with prices 0 and stock unchanged.
- Restock:
  - restock_valid with restock_type 00–10 adds restock_qty to that stock, saturating at 65535.
  - Type 11 is ignored.
  - Restock produces no response.
- Simultaneous request and restock on the same fluid: the request is judged against the pre-restock stock. The committed stock is stock − dispensed + restock_qty. remaining_qty reports the committed value.
- Reset asserted mid-operation clears all state immediately. A request pending on that edge is dropped.

Optional Feature:
LOW_STOCK_ALARM_EN
- Defined: adds output low_stock[2:0], registered, bit i = (stock[i] < LOW_THRESH); reset value 3'b000 while reset is asserted, evaluated against the INIT_STOCK levels from the first clock edge after release.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package fluid_pkg holds:
  - fluid type enum (WATER, JUICE, CHEM, INVALID);
  - message codes;
  - default price constants;
  - a discount-tier function mapping visits to percent.
- One sub-module, visit_counter_bank:
  - 16×8-bit saturating counters;
  - inputs inc_en and user_id;
  - output is the incremented count, available combinationally for pricing in the same cycle.

Test Plan:
- After reset: user1, water, 1 L → visits 1, disc 0, orig 10, final 10, remaining 49, msg 0.
- user1 water 2 L (visit 2): disc 5, orig 20, final 19, remaining 47.
- user1 juice 5 L (visit 3) → disc 10, orig 150, final 135, juice remaining 45. Then two more user1 water 1 L requests: the visit-5 response shows disc 20, orig 10, final 8, water remaining 45.
- user4 chem 3 L → orig 150, final 150, remaining 47. Then user6 chem 70 L → msg 1, prices 0, remaining 47, visits 1, stock unchanged.
- fluid 11 → msg 2, visit counted. Restock chem by 30 concurrently with a chem 60 L request at stock 47 → msg 1 and remaining 77; then a chem 60 L request → msg 0, remaining 17.
- Pulse reset low mid-sequence → all outputs 0 and stocks 50. req_valid=0 cycles leave all state unchanged and resp_valid=0.
